// File: rtl/prime_job_sched.sv
// ============================================================================
// Module   : prime_job_sched
// Purpose  : Bus-mapped FIFO of prime-index jobs dispatched to a prime engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

module prime_job_sched #(
  parameter int DEPTH     = 4,
  parameter int MAX_INDEX = 1000,
  parameter int TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] saddress,
  input  logic        swr,
  input  logic        srd,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  output logic        eng_start,
  output logic [9:0]  eng_index,
  input  logic        eng_done,
  input  logic [31:0] eng_result,
  output logic [31:0] gpio_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [15:0] ADDR_PUSH   = 16'h0258;
  localparam logic [15:0] ADDR_RESULT = 16'h0268;
  localparam logic [15:0] ADDR_STATUS = 16'h0270;
  localparam logic [15:0] ADDR_CTRL   = 16'h0278;

  localparam logic [31:0]   NO_RESULT = 32'hAAAA_AAAA;
  localparam logic [31:0]   MAX_IDX   = 32'(MAX_INDEX);
  localparam logic [31:0]   TMO       = 32'(TIMEOUT);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);

  logic [1:0]    state_q, state_d;
  logic          swr_q, srd_q;
  logic [9:0]    queue_q [DEPTH];
  logic [9:0]    queue_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   wait_cnt_q, wait_cnt_d;
  logic [31:0]   result_q, result_d;
  logic          res_valid_q, res_valid_d;
  logic          overflow_q, overflow_d;
  logic          bad_idx_q, bad_idx_d;
  logic          timeout_q, timeout_d;
  logic [15:0]   done_cnt_q, done_cnt_d;
  logic [31:0]   sdata_out_q, sdata_out_d;

  logic       wr_edge, rd_edge, push_req, idx_bad, push_ok, pop;
  logic       flush, clr, capture, expire, busy;
  logic [9:0] push_idx;
  logic [2:0] count3;
  logic       unused_bits;

  assign wr_edge  = swr & ~swr_q;
  assign rd_edge  = srd & ~srd_q;
  assign push_idx = sdata_in[9:0];
  assign push_req = wr_edge && (saddress == ADDR_PUSH);
  assign idx_bad  = (push_idx == 10'd0) || ({22'd0, push_idx} > MAX_IDX);
  assign push_ok  = push_req && !idx_bad && (count_q != FULL);
  assign pop      = (state_q == ST_ISSUE);
  assign flush    = wr_edge && (saddress == ADDR_CTRL) && sdata_in[1];
  assign clr      = wr_edge && (saddress == ADDR_CTRL) && sdata_in[0];
  assign capture  = (state_q == ST_WAIT) && eng_done;
  // Expires on the TIMEOUT-th waiting cycle that has no completion.
  assign expire   = (state_q == ST_WAIT) && !eng_done && ((wait_cnt_q + 32'd1) >= TMO);
  assign busy     = (state_q != ST_IDLE) || (count_q != '0);
  assign count3   = 3'(count_q);

  assign unused_bits = &{1'b0, sdata_in[31:10]};

  assign sdata_out = sdata_out_q;
  assign gpio_out  = {16'd0, done_cnt_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if ((count_q != '0) && !res_valid_q) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (eng_done || expire) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    eng_start = 1'b0;
    eng_index = 10'd0;
    if (state_q == ST_ISSUE) begin
      eng_start = 1'b1;
      eng_index = queue_q[rd_ptr_q];
    end
  end

  always_comb begin
    queue_d     = queue_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wait_cnt_d  = wait_cnt_q;
    result_d    = result_q;
    res_valid_d = res_valid_q;
    overflow_d  = overflow_q;
    bad_idx_d   = bad_idx_q;
    timeout_d   = timeout_q;
    done_cnt_d  = done_cnt_q;
    sdata_out_d = sdata_out_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        queue_d[wr_ptr_q] = push_idx;
        wr_ptr_d          = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    if (clr) begin
      overflow_d = 1'b0;
      bad_idx_d  = 1'b0;
      timeout_d  = 1'b0;
    end
    if (push_req && idx_bad) bad_idx_d = 1'b1;
    if (push_req && !idx_bad && (count_q == FULL)) overflow_d = 1'b1;

    if (rd_edge) begin
      case (saddress)
        ADDR_RESULT: begin
          if (res_valid_q) begin
            sdata_out_d = result_q;
            res_valid_d = 1'b0;
          end else begin
            sdata_out_d = NO_RESULT;
          end
        end
        ADDR_STATUS: sdata_out_d = {24'd0, timeout_q, bad_idx_q, overflow_q,
                                    count3, res_valid_q, busy};
        default:     sdata_out_d = 32'd0;
      endcase
    end

    if (state_q == ST_ISSUE) wait_cnt_d = 32'd0;
    else if (state_q == ST_WAIT) wait_cnt_d = wait_cnt_q + 32'd1;

    // A completion or expiry lands after the read so a fresh result survives.
    if (capture) begin
      result_d    = eng_result;
      res_valid_d = 1'b1;
      done_cnt_d  = done_cnt_q + 16'd1;
    end else if (expire) begin
      result_d    = NO_RESULT;
      res_valid_d = 1'b1;
      timeout_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      swr_q       <= 1'b0;
      srd_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) queue_q[i] <= 10'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wait_cnt_q  <= 32'd0;
      result_q    <= 32'd0;
      res_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      bad_idx_q   <= 1'b0;
      timeout_q   <= 1'b0;
      done_cnt_q  <= 16'd0;
      sdata_out_q <= 32'd0;
    end else begin
      swr_q       <= swr;
      srd_q       <= srd;
      queue_q     <= queue_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wait_cnt_q  <= wait_cnt_d;
      result_q    <= result_d;
      res_valid_q <= res_valid_d;
      overflow_q  <= overflow_d;
      bad_idx_q   <= bad_idx_d;
      timeout_q   <= timeout_d;
      done_cnt_q  <= done_cnt_d;
      sdata_out_q <= sdata_out_d;
    end
  end

endmodule

`default_nettype wire
